serializer_ddr_multi: RTL and testbench

- Parametrised multi-channel N:1 parallel-to-DDR serializer for the TMDS/HDMI transmit path.
- Accepts one word per channel through a valid/ready handshake in the serial clock domain, buffers it, and each cycle emits a rise/fall bit pair per channel.
- The outputs feed vendor ODDR and output-buffer primitives that sit outside this block.
- Adds over the fixed 10:1 design: configurable width and channel count, bit order, per-channel polarity inversion, an underflow idle-word fill, and a word-sync strobe.

---
 rtl/serializer_ddr_multi.sv | 183 ++++++++++++++++++
 tb/tb_serializer_ddr_multi.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_ddr_multi.sv
// rtl/serializer_ddr_multi.sv - multi-lane N:1 parallel-to-DDR serializer
//
// Purpose: accepts one WORD_W-bit word per lane through a valid/ready handshake,
// buffers it in a single-entry holding register and, each serial clock cycle,
// presents a rise/fall bit pair per lane for external ODDR primitives.
//
// Ports:
//   serial_clk_5x  in   serial (half-bit-rate) clock, rising edge only
//   rst            in   asynchronous reset, active-high
//   word_data      in   CHANNELS*WORD_W, lane c at [c*WORD_W +: WORD_W]
//   word_valid     in   word_data valid
//   word_ready     out  word_data accepted this cycle when valid
//   ser_rise       out  CHANNELS, rising-edge DDR bit per lane
//   ser_fall       out  CHANNELS, falling-edge DDR bit per lane
//   word_sync      out  high during phase 0 (first bit pair of each word)
//   underflow      out  sticky, a load found the holding register empty
//   underflow_clr  in   clears underflow (a simultaneous set wins)
//   prbs_mode      in   only with SER_PRBS_EN: lanes send PRBS7 instead of data
//
// Optional feature macro: SER_PRBS_EN (per-lane PRBS7 source, x^7+x^6+1).
module serializer_ddr_multi #(
  parameter int                   CHANNELS    = 4,
  parameter int                   WORD_W      = 10,
  parameter bit                   LSB_FIRST   = 1'b1,
  parameter logic [CHANNELS-1:0]  INVERT_MASK = {CHANNELS{1'b0}},
  parameter logic [WORD_W-1:0]    IDLE_WORD   = WORD_W'(10'b1101010100)
) (
  input  logic                         serial_clk_5x,
  input  logic                         rst,
  input  logic [CHANNELS*WORD_W-1:0]   word_data,
  input  logic                         word_valid,
  output logic                         word_ready,
  output logic [CHANNELS-1:0]          ser_rise,
  output logic [CHANNELS-1:0]          ser_fall,
  output logic                         word_sync,
  output logic                         underflow,
  input  logic                         underflow_clr
`ifdef SER_PRBS_EN
  ,
  input  logic                         prbs_mode
`endif
);

  localparam int HALF = WORD_W / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(HALF - 1);

  if ((WORD_W % 2) != 0 || WORD_W < 4) begin : g_bad_width
    $error("WORD_W must be even and at least 4");
  end

  logic [PW-1:0]                  phase_q, phase_d;
  logic                           hold_valid_q, hold_valid_d;
  logic [CHANNELS*WORD_W-1:0]     hold_data_q, hold_data_d;
  logic [CHANNELS-1:0][HALF-1:0]  rise_shift_q, rise_shift_d;
  logic [CHANNELS-1:0][HALF-1:0]  fall_shift_q, fall_shift_d;
  logic                           word_sync_q, word_sync_d;
  logic                           underflow_q, underflow_d;
  logic                           load, accept, use_prbs;

  assign load = (phase_q == LAST_PHASE);

`ifdef SER_PRBS_EN
  logic [CHANNELS-1:0][6:0]       lfsr_q, lfsr_d;
  logic [CHANNELS-1:0][WORD_W-1:0] prbs_word;

  assign use_prbs = prbs_mode;
  // In PRBS mode the hold register is frozen, so a full hold must not be
  // overwritten at the load cycle.
  assign word_ready = !hold_valid_q | (load & !prbs_mode);

  // Each load consumes WORD_W LFSR steps; the newly shifted-in bit of each
  // step becomes the next word bit, starting at bit 0.
  always_comb begin
    logic [6:0] s;
    s         = '0;
    lfsr_d    = lfsr_q;
    prbs_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      s = lfsr_q[c];
      for (int b = 0; b < WORD_W; b++) begin
        s = {s[5:0], s[6] ^ s[5]};
        prbs_word[c][b] = s[0];
      end
      if (load && prbs_mode) lfsr_d[c] = s;
    end
  end
`else
  assign use_prbs   = 1'b0;
  assign word_ready = !hold_valid_q | load;
`endif

  assign accept = word_valid & word_ready;

  always_comb begin
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] wr;
    w            = '0;
    wr           = '0;
    phase_d      = load ? '0 : phase_q + PW'(1);
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    rise_shift_d = rise_shift_q;
    fall_shift_d = fall_shift_q;
    underflow_d  = underflow_q;
    // Registered so that it is high while phase 0 is on the outputs.
    word_sync_d  = load;

    // A word accepted in the load cycle lands in hold; it never bypasses.
    if (load && !use_prbs) hold_valid_d = 1'b0;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = word_data;
    end

    if (underflow_clr) underflow_d = 1'b0;
    if (load && !use_prbs && !hold_valid_q) underflow_d = 1'b1;

    for (int c = 0; c < CHANNELS; c++) begin
      if (load) begin
        w = hold_valid_q ? hold_data_q[c*WORD_W +: WORD_W] : IDLE_WORD;
`ifdef SER_PRBS_EN
        if (prbs_mode) w = prbs_word[c];
`endif
        // MSB-first is the LSB-first split applied to the bit-reversed word.
        for (int i = 0; i < WORD_W; i++) begin
          wr[i] = LSB_FIRST ? w[i] : w[WORD_W-1-i];
        end
        wr = wr ^ {WORD_W{INVERT_MASK[c]}};
        for (int i = 0; i < HALF; i++) begin
          rise_shift_d[c][i] = wr[2*i];
          fall_shift_d[c][i] = wr[2*i+1];
        end
      end else begin
        rise_shift_d[c] = rise_shift_q[c] >> 1;
        fall_shift_d[c] = fall_shift_q[c] >> 1;
      end
    end
  end

  always_ff @(posedge serial_clk_5x or posedge rst) begin
    if (rst) begin
      phase_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      rise_shift_q <= '0;
      fall_shift_q <= '0;
      word_sync_q  <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      rise_shift_q <= rise_shift_d;
      fall_shift_q <= fall_shift_d;
      word_sync_q  <= word_sync_d;
      underflow_q  <= underflow_d;
    end
  end

`ifdef SER_PRBS_EN
  always_ff @(posedge serial_clk_5x or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) lfsr_q[c] <= 7'h7F ^ 7'(c);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  always_comb begin
    ser_rise = '0;
    ser_fall = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ser_rise[c] = rise_shift_q[c][0];
      ser_fall[c] = fall_shift_q[c][0];
    end
  end

  assign word_sync = word_sync_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_serializer_ddr_multi.sv
// tb/tb_serializer_ddr_multi.sv - self-checking bench for serializer_ddr_multi
module tb_serializer_ddr_multi;
  localparam int CH   = 4;
  localparam int W    = 10;
  localparam int HALF = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH*W-1:0] word_data = '0;
  logic            word_valid = 1'b0;
  logic            underflow_clr = 1'b0;

  logic            word_ready, word_sync, underflow;
  logic [CH-1:0]   ser_rise, ser_fall;
  logic            m_word_ready, m_word_sync, m_underflow;
  logic [CH-1:0]   m_ser_rise, m_ser_fall;
  logic            i_word_ready, i_word_sync, i_underflow;
  logic [CH-1:0]   i_ser_rise, i_ser_fall;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [CH-1:0] q_rise[$];
  logic [CH-1:0] q_fall[$];

  always #5 clk = ~clk;

  serializer_ddr_multi dut (
    .serial_clk_5x(clk), .rst(rst), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .ser_rise(ser_rise), .ser_fall(ser_fall),
    .word_sync(word_sync), .underflow(underflow), .underflow_clr(underflow_clr)
  );

  serializer_ddr_multi #(.LSB_FIRST(1'b0)) dut_msb (
    .serial_clk_5x(clk), .rst(rst), .word_data(word_data), .word_valid(word_valid),
    .word_ready(m_word_ready), .ser_rise(m_ser_rise), .ser_fall(m_ser_fall),
    .word_sync(m_word_sync), .underflow(m_underflow), .underflow_clr(underflow_clr)
  );

  serializer_ddr_multi #(.INVERT_MASK(4'b1000)) dut_inv (
    .serial_clk_5x(clk), .rst(rst), .word_data(word_data), .word_valid(word_valid),
    .word_ready(i_word_ready), .ser_rise(i_ser_rise), .ser_fall(i_ser_fall),
    .word_sync(i_word_sync), .underflow(i_underflow), .underflow_clr(underflow_clr)
  );

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    word_valid    = 1'b0;
    underflow_clr = 1'b0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    q_rise.delete();
    q_fall.delete();
  endtask

  // Expected rise/fall pairs of one word sent identically on every lane.
  function automatic void push_word(input logic [W-1:0] w, input bit lsb,
                                    input logic [CH-1:0] inv);
    logic [W-1:0]  o;
    logic [CH-1:0] r, f;
    for (int i = 0; i < HALF; i++) begin
      for (int c = 0; c < CH; c++) begin
        o = w;
        if (!lsb) for (int b = 0; b < W; b++) o[b] = w[W-1-b];
        if (inv[c]) o = ~o;
        r[c] = o[2*i];
        f[c] = o[2*i+1];
      end
      q_rise.push_back(r);
      q_fall.push_back(f);
    end
  endfunction

  task automatic test_reset();
    word_valid = 1'b0; underflow_clr = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ser_rise !== 4'h0 || ser_fall !== 4'h0) begin
      errors++; $display("FAIL reset_ser: got rise=%b fall=%b expected 0000/0000", ser_rise, ser_fall);
    end
    checks++;
    if (word_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", word_ready);
    end
    checks++;
    if (word_sync !== 1'b0) begin
      errors++; $display("FAIL reset_sync: got %b expected 0", word_sync);
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("FAIL reset_underflow: got %b expected 0", underflow);
    end
  endtask

  task automatic test_idle_after_reset();
    logic [4:0] rs;
    logic [4:0] fs;
    logic [CH-1:0] er, ef;
    rs = 5'b11110;
    fs = 5'b10000;
    rst = 1'b0; cyc = 0; q_rise.delete(); q_fall.delete();
    for (int i = 0; i < HALF; i++) begin
      q_rise.push_back({CH{rs[i]}});
      q_fall.push_back({CH{fs[i]}});
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (word_sync !== (cyc % HALF == 0)) begin
        errors++; $display("FAIL idle_sync cyc%0d: got %b expected %b", cyc, word_sync, (cyc % HALF == 0));
      end
      if (cyc >= 5 && q_rise.size() > 0) begin
        er = q_rise.pop_front(); ef = q_fall.pop_front();
        checks++;
        if (ser_rise !== er || ser_fall !== ef) begin
          errors++; $display("FAIL idle_pair cyc%0d: got rise=%b fall=%b expected rise=%b fall=%b", cyc, ser_rise, ser_fall, er, ef);
        end
      end
    end
    checks++;
    if (underflow !== 1'b1) begin
      errors++; $display("FAIL idle_underflow: got %b expected 1", underflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  wl[3];
    logic [CH-1:0] er, ef;
    int idx, lows, gap3, pops;
    bit acc;
    wl[0] = 10'h3FF; wl[1] = 10'h000; wl[2] = 10'h2AA;
    apply_reset();
    idx = 0; lows = 0; gap3 = -1; pops = 0;
    word_valid = 1'b1; word_data = {CH{wl[0]}};
    for (int n = 0; n < 20; n++) begin
      acc = word_valid && word_ready;
      if (word_valid && !word_ready) lows++;
      tick();
      if (acc) begin
        push_word(wl[idx], 1'b1, 4'b0000);
        if (idx == 2) gap3 = lows;
        lows = 0;
        idx++;
        if (idx < 3) word_data = {CH{wl[idx]}};
        else word_valid = 1'b0;
      end
      if (cyc >= 5) begin
        checks++;
        if (word_sync !== (cyc % HALF == 0)) begin
          errors++; $display("FAIL b2b_sync cyc%0d: got %b expected %b", cyc, word_sync, (cyc % HALF == 0));
        end
      end
      if (cyc >= 5 && q_rise.size() > 0) begin
        er = q_rise.pop_front(); ef = q_fall.pop_front(); pops++;
        checks++;
        if (ser_rise !== er || ser_fall !== ef) begin
          errors++; $display("FAIL b2b_pair cyc%0d: got rise=%b fall=%b expected rise=%b fall=%b", cyc, ser_rise, ser_fall, er, ef);
        end
      end
      if (cyc == 19) begin
        checks++;
        if (underflow !== 1'b0) begin
          errors++; $display("FAIL b2b_underflow: got %b expected 0", underflow);
        end
      end
    end
    checks++;
    if (idx != 3 || pops != 15) begin
      errors++; $display("FAIL b2b_count: got accepted=%0d pairs=%0d expected 3/15", idx, pops);
    end
    checks++;
    if (gap3 != 4) begin
      errors++; $display("FAIL b2b_stall: got %0d ready-low cycles expected 4", gap3);
    end
  endtask

  task automatic test_msb_first();
    logic [CH-1:0] er, ef;
    int idx, pops;
    bit acc;
    apply_reset();
    idx = 0; pops = 0;
    word_valid = 1'b1; word_data = {CH{10'b1000000001}};
    for (int n = 0; n < 15; n++) begin
      acc = word_valid && m_word_ready;
      tick();
      if (acc) begin
        if (idx == 0) begin
          q_rise.push_back(4'hF); q_fall.push_back(4'h0);
          for (int i = 0; i < 3; i++) begin q_rise.push_back(4'h0); q_fall.push_back(4'h0); end
          q_rise.push_back(4'h0); q_fall.push_back(4'hF);
          word_data = {CH{10'b0000000011}};
        end else begin
          push_word(10'b0000000011, 1'b0, 4'b0000);
          word_valid = 1'b0;
        end
        idx++;
      end
      if (cyc >= 5 && q_rise.size() > 0) begin
        er = q_rise.pop_front(); ef = q_fall.pop_front(); pops++;
        checks++;
        if (m_ser_rise !== er || m_ser_fall !== ef) begin
          errors++; $display("FAIL msb_pair cyc%0d: got rise=%b fall=%b expected rise=%b fall=%b", cyc, m_ser_rise, m_ser_fall, er, ef);
        end
      end
    end
    checks++;
    if (pops != 10) begin
      errors++; $display("FAIL msb_count: got %0d pairs expected 10", pops);
    end
  endtask

  task automatic test_invert();
    logic [CH-1:0] er, ef;
    apply_reset();
    word_valid = 1'b1; word_data = {CH{10'h155}};
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < HALF; i++) begin q_rise.push_back(4'b0111); q_fall.push_back(4'b1000); end
    for (int n = 0; n < 8; n++) begin
      tick();
      if (cyc >= 5 && q_rise.size() > 0) begin
        er = q_rise.pop_front(); ef = q_fall.pop_front();
        checks++;
        if (i_ser_rise !== er || i_ser_fall !== ef) begin
          errors++; $display("FAIL invert_pair cyc%0d: got rise=%b fall=%b expected rise=%b fall=%b", cyc, i_ser_rise, i_ser_fall, er, ef);
        end
      end
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    repeat (5) tick();
    checks++;
    if (underflow !== 1'b1) begin
      errors++; $display("FAIL uf_set: got %b expected 1", underflow);
    end
    tick();
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("FAIL uf_clear: got %b expected 0", underflow);
    end
    repeat (2) tick();
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("FAIL uf_hold0: got %b expected 0", underflow);
    end
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin
      errors++; $display("FAIL uf_set_wins: got %b expected 1", underflow);
    end
  endtask

  task automatic test_reset_midword();
    logic [CH-1:0] er, ef;
    apply_reset();
    word_valid = 1'b1; word_data = {CH{10'h3FF}};
    repeat (5) tick();
    word_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (ser_rise !== 4'hF || ser_fall !== 4'hF) begin
      errors++; $display("FAIL mid_before: got rise=%b fall=%b expected 1111/1111", ser_rise, ser_fall);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ser_rise !== 4'h0 || ser_fall !== 4'h0) begin
      errors++; $display("FAIL mid_async: got rise=%b fall=%b expected 0000/0000", ser_rise, ser_fall);
    end
    @(negedge clk);
    rst = 1'b0; cyc = 0; q_rise.delete(); q_fall.delete();
    push_word(10'b1101010100, 1'b1, 4'b0000);
    for (int n = 0; n < 10; n++) begin
      tick();
      if (cyc >= 5 && q_rise.size() > 0) begin
        er = q_rise.pop_front(); ef = q_fall.pop_front();
        checks++;
        if (ser_rise !== er || ser_fall !== ef) begin
          errors++; $display("FAIL mid_idle cyc%0d: got rise=%b fall=%b expected rise=%b fall=%b", cyc, ser_rise, ser_fall, er, ef);
        end
      end
      if (cyc == 5) begin
        checks++;
        if (underflow !== 1'b1) begin
          errors++; $display("FAIL mid_underflow: got %b expected 1", underflow);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_after_reset();
    test_back_to_back();
    test_msb_first();
    test_invert();
    test_underflow();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
